// File: rtl/dmac_prirr_arb.sv
// Priority arbiter with round-robin tie-break, bus lock with optional tenure limit,
// and park-on-idle. All outputs are registered.
module dmac_prirr_arb #(
    parameter int N           = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int PARK_MODE   = 1,
    parameter int PARK_INDEX  = 0,
    parameter int MAX_LOCK    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_n,
    input  logic                       enable,
    input  logic [N-1:0]               request,
    input  logic [N-1:0]               mask,
    input  logic [N-1:0]               lock,
    input  logic [N*INDEX_WIDTH-1:0]   prior,
    output logic [N-1:0]               grant,
    output logic [INDEX_WIDTH-1:0]     grant_index,
    output logic                       granted,
    output logic                       locked,
    output logic                       parked,
    output logic                       lock_expired
);

    typedef enum logic [1:0] {ST_PARK, ST_GRANT, ST_LOCK} state_t;

    localparam logic [N-1:0] PARK_GRANT =
        (PARK_MODE != 0) ? ({{(N-1){1'b0}}, 1'b1} << PARK_INDEX) : '0;
    localparam logic [INDEX_WIDTH-1:0] PARK_IDX =
        (PARK_MODE != 0) ? INDEX_WIDTH'(PARK_INDEX) : '1;
    localparam logic [INDEX_WIDTH-1:0] RR_INIT = INDEX_WIDTH'(N - 1);

    state_t                 r_state;
    logic [N-1:0]           r_grant;
    logic [INDEX_WIDTH-1:0] r_grant_index;
    logic                   r_granted;
    logic                   r_locked;
    logic                   r_parked;
    logic                   r_lock_expired;
    logic [INDEX_WIDTH-1:0] r_rr_ptr;
    logic [7:0]             r_lock_cnt;
    logic [N-1:0]           r_blk;      // one-hot: expired owner barred from relocking

    logic [N-1:0]           w_elig;
    logic [N-1:0]           w_cand;
    logic [N-1:0]           w_tied;
    logic [N-1:0]           w_win_onehot;
    logic [INDEX_WIDTH-1:0] w_min;
    logic [INDEX_WIDTH-1:0] w_win_idx;
    logic [INDEX_WIDTH-1:0] w_j;
    logic                   w_found;
    logic                   w_any;
    logic                   w_owner_lock;
    logic                   w_force;
    logic                   w_stay_lock;
    logic                   w_enter_lock;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_elig       = request & ~mask;
        w_owner_lock = |(lock & ~mask & r_grant);
        w_force      = (MAX_LOCK > 0) && (r_state == ST_LOCK) && w_owner_lock &&
                       (r_lock_cnt == 8'(MAX_LOCK));
        w_stay_lock  = (r_state == ST_LOCK) && w_owner_lock && !w_force;
        w_enter_lock = (r_state == ST_GRANT) && w_owner_lock && ((r_blk & r_grant) == '0);

        w_cand = w_elig;
        if (w_force && ((w_elig & ~r_grant) != '0))
            w_cand = w_elig & ~r_grant;
        w_any = |w_cand;

        w_min = '1;
        for (int i = 0; i < N; i++)
            if (w_cand[i] && (prior[i*INDEX_WIDTH +: INDEX_WIDTH] < w_min))
                w_min = prior[i*INDEX_WIDTH +: INDEX_WIDTH];
        for (int i = 0; i < N; i++)
            w_tied[i] = w_cand[i] && (prior[i*INDEX_WIDTH +: INDEX_WIDTH] == w_min);

        // Scan starts one past the last winner and wraps.
        w_found      = 1'b0;
        w_win_idx    = '0;
        w_win_onehot = '0;
        w_j          = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = INDEX_WIDTH'((int'(r_rr_ptr) + k) % N);
            if (!w_found && w_tied[w_j]) begin
                w_found           = 1'b1;
                w_win_idx         = w_j;
                w_win_onehot[w_j] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_PARK;
            r_grant        <= PARK_GRANT;
            r_grant_index  <= PARK_IDX;
            r_granted      <= 1'b0;
            r_locked       <= 1'b0;
            r_parked       <= (PARK_MODE != 0);
            r_lock_expired <= 1'b0;
            r_rr_ptr       <= RR_INIT;
            r_lock_cnt     <= '0;
            r_blk          <= '0;
        end else if (!init_n) begin
            r_state        <= ST_PARK;
            r_grant        <= PARK_GRANT;
            r_grant_index  <= PARK_IDX;
            r_granted      <= 1'b0;
            r_locked       <= 1'b0;
            r_parked       <= (PARK_MODE != 0);
            r_lock_expired <= 1'b0;
            r_rr_ptr       <= RR_INIT;
            r_lock_cnt     <= '0;
            r_blk          <= '0;
        end else if (!enable) begin
            r_lock_expired <= 1'b0;
        end else begin
            r_lock_expired <= w_force;
            if ((r_blk & lock) == '0)
                r_blk <= '0;
            if (w_force)
                r_blk <= r_grant;

            if (w_stay_lock) begin
                if ((MAX_LOCK > 0) && (r_lock_cnt != 8'hFF))
                    r_lock_cnt <= r_lock_cnt + 8'd1;
            end else if (w_enter_lock) begin
                r_state    <= ST_LOCK;
                r_locked   <= 1'b1;
                r_lock_cnt <= (MAX_LOCK > 0) ? 8'd1 : 8'd0;
            end else begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
                if (w_any) begin
                    r_state       <= ST_GRANT;
                    r_grant       <= w_win_onehot;
                    r_grant_index <= w_win_idx;
                    r_rr_ptr      <= w_win_idx;
                    r_granted     <= 1'b1;
                    r_parked      <= 1'b0;
                end else begin
                    r_state       <= ST_PARK;
                    r_grant       <= PARK_GRANT;
                    r_grant_index <= PARK_IDX;
                    r_granted     <= 1'b0;
                    r_parked      <= (PARK_MODE != 0);
                end
            end
        end
    end

    assign grant        = r_grant;
    assign grant_index  = r_grant_index;
    assign granted      = r_granted;
    assign locked       = r_locked;
    assign parked       = r_parked;
    assign lock_expired = r_lock_expired;

endmodule

// File: tb/tb_dmac_prirr_arb.sv
// Vector-table bench for dmac_prirr_arb (N=4, INDEX_WIDTH=2, park on 0, MAX_LOCK=3);
// each row is one clock of stimulus and the registered outputs expected after it.
module tb_dmac_prirr_arb;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n, init_n, enable;
    logic [N-1:0]  request, mask, lock;
    logic [N*IW-1:0] prior;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_index;
    logic          granted, locked, parked, lock_expired;

    dmac_prirr_arb #(
        .N(N), .INDEX_WIDTH(IW), .PARK_MODE(1), .PARK_INDEX(0), .MAX_LOCK(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .enable(enable),
        .request(request), .mask(mask), .lock(lock), .prior(prior),
        .grant(grant), .grant_index(grant_index), .granted(granted),
        .locked(locked), .parked(parked), .lock_expired(lock_expired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       granted;
        logic       locked;
        logic       parked;
        logic       expired;
    } out_t;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [3:0] msk;
        logic [3:0] lck;
        logic [7:0] pri;
        logic       init_n;
        logic       en;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic out_t mk(input logic [3:0] g, input logic [1:0] i, input logic gd,
                                input logic lk, input logic pk, input logic ex);
        out_t o;
        o.grant = g; o.idx = i; o.granted = gd; o.locked = lk; o.parked = pk; o.expired = ex;
        return o;
    endfunction

    task automatic add(input string nm, input logic [3:0] r, input logic [3:0] m,
                       input logic [3:0] l, input logic [7:0] p, input logic in_n,
                       input logic en, input out_t e);
        vec_t v;
        v.name = nm; v.req = r; v.msk = m; v.lck = l; v.pri = p;
        v.init_n = in_n; v.en = en; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic out_t actual();
        return mk(grant, grant_index, granted, locked, parked, lock_expired);
    endfunction

    task automatic check(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got grant=%b idx=%0d granted=%b locked=%b parked=%b expired=%b, want grant=%b idx=%0d granted=%b locked=%b parked=%b expired=%b",
                     nm, a.grant, a.idx, a.granted, a.locked, a.parked, a.expired,
                     e.grant, e.idx, e.granted, e.locked, e.parked, e.expired);
        end
    endtask

    initial begin
        rst_n = 1'b0; init_n = 1'b1; enable = 1'b1;
        request = '0; mask = '0; lock = '0; prior = 8'h55;

        // Idle park, then all-equal round robin from reset pointer 3.
        add("idle_park",  4'b0000, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 0, 0, 1, 0));
        add("rr_0",       4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        add("rr_1",       4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0010, 1, 1, 0, 0, 0));
        add("rr_2",       4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        add("rr_3",       4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b1000, 3, 1, 0, 0, 0));
        add("rr_wrap",    4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        // Priority beats round robin: client 2 (prio 1) over client 1 (prio 2).
        add("prio_a",     4'b0110, 4'b0000, 4'b0000, 8'h59, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        add("prio_b",     4'b0110, 4'b0000, 4'b0000, 8'h59, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        add("prio_c",     4'b0110, 4'b0000, 4'b0000, 8'h59, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        // Lock by client 2 expires after 3 cycles, grant moves to 3, no relock while lock held.
        add("lock_1",     4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 1, 0, 0));
        add("lock_2",     4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 1, 0, 0));
        add("lock_3",     4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 1, 0, 0));
        add("expire",     4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b1000, 3, 1, 0, 0, 1));
        add("post_exp0",  4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        add("post_exp1",  4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0010, 1, 1, 0, 0, 0));
        add("regrant_2",  4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        add("no_relock",  4'b1111, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b1000, 3, 1, 0, 0, 0));
        add("lock_drop",  4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        // Lock dominates request; release with nothing pending parks.
        add("g2_again",   4'b0100, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        add("relock_ok",  4'b0000, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 1, 0, 0));
        add("req_drop",   4'b0000, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 1, 0, 0));
        add("unlock_prk", 4'b0000, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 0, 0, 1, 0));
        // Masking the lock owner breaks the lock; client 0 has top priority.
        add("g1",         4'b0010, 4'b0000, 4'b0000, 8'h54, 1, 1, mk(4'b0010, 1, 1, 0, 0, 0));
        add("lock1",      4'b1011, 4'b0000, 4'b0010, 8'h54, 1, 1, mk(4'b0010, 1, 1, 1, 0, 0));
        add("mask_owner", 4'b1011, 4'b0010, 4'b0010, 8'h54, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        add("en_hold",    4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 0, mk(4'b0001, 0, 1, 0, 0, 0));
        // init_n during a lock, ignoring enable; pointer back to 3.
        add("g2_init",    4'b0100, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 0, 0, 0));
        add("lock_init",  4'b0100, 4'b0000, 4'b0100, 8'h55, 1, 1, mk(4'b0100, 2, 1, 1, 0, 0));
        add("init_pulse", 4'b1111, 4'b0000, 4'b0100, 8'h55, 0, 0, mk(4'b0001, 0, 0, 0, 1, 0));
        add("after_init", 4'b1111, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        // Expiry pulse cleared by enable=0; lone expired owner regranted but not relocked.
        add("l0_1",       4'b1111, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 1, 0, 0));
        add("l0_2",       4'b1111, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 1, 0, 0));
        add("l0_3",       4'b1111, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 1, 0, 0));
        add("l0_expire",  4'b1111, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0010, 1, 1, 0, 0, 1));
        add("exp_en_off", 4'b1111, 4'b0000, 4'b0001, 8'h55, 1, 0, mk(4'b0010, 1, 1, 0, 0, 0));
        add("only0_a",    4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        add("only0_blk",  4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        add("only0_rel",  4'b0001, 4'b0000, 4'b0000, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));
        add("only0_l1",   4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 1, 0, 0));
        add("only0_l2",   4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 1, 0, 0));
        add("only0_l3",   4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 1, 0, 0));
        add("only0_exp",  4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 1));
        add("only0_nolk", 4'b0001, 4'b0000, 4'b0001, 8'h55, 1, 1, mk(4'b0001, 0, 1, 0, 0, 0));

        #12;
        sb.push_back(mk(4'b0001, 0, 0, 0, 1, 0));
        check("reset", actual(), sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            request = vecs[k].req;
            mask    = vecs[k].msk;
            lock    = vecs[k].lck;
            prior   = vecs[k].pri;
            init_n  = vecs[k].init_n;
            enable  = vecs[k].en;
            sb.push_back(vecs[k].exp);
            @(posedge clk);
            #1;
            check(vecs[k].name, actual(), sb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
